riscv_seq_ctrl: RTL and testbench
=================================

// Module: riscv_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB FSM.
//  Drives instruction/data memory req/ack handshakes, PC update, register
//  write-back and datapath selects for the implemented opcode subset
//  (0x13, 0x03, 0x33, 0x6F, 0x23, 0x37, 0x63).
//  Traps on illegal opcodes and on memory handshake timeouts.
// PARAMETERS
//  MEM_TIMEOUT  15  cycles req may wait for ack before trap; 0 disables the timeout
//  CNT_W        32  width of retire_cnt
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  imem_req      out  1      instruction fetch request
//  imem_ack      in   1      fetch done; instr valid this cycle
//  instr         in   32     fetched instruction word
//  dmem_req      out  1      data memory request
//  dmem_we       out  1      1=store, 0=load (valid with dmem_req)
//  dmem_ack      in   1      data access done
//  branch_taken  in   1      ALU compare result for bne
//  ir            out  32     latched instruction register
//  pc_we         out  1      PC load strobe
//  pc_sel        out  2      00 pc+4, 01 branch target, 10 jal target
//  reg_we        out  1      register file write strobe
//  wb_sel        out  2      00 ALU, 01 mem data, 10 pc+4, 11 U-imm (lui)
//  alu_src       out  1      0=rs2, 1=immediate
//  imm_sel       out  3      000 I, 001 S, 010 B, 011 U, 100 J
//  retire        out  1      1-cycle pulse per completed instruction
//  retire_cnt    out  CNT_W  retired instruction count, wraps to 0
//  fault         out  1      sticky trap flag
//  fault_code    out  2      01 illegal opcode, 10 imem timeout, 11 dmem timeout
//  state         out  3      FSM state (debug)
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
//  Reset: state=FETCH, ir=0, retire_cnt=0, fault=0, fault_code=00, timeout counter=0.
//    All strobes (imem_req, dmem_req, dmem_we, pc_we, reg_we, retire) and selects are 0.
//    From the first cycle after reset, imem_req=1 in FETCH.
//  Reset mid-operation: abandons any pending request; same values next edge.
//  FETCH: imem_req=1, held until imem_ack.
//    On ack: ir<=instr, then DECODE. Acks while req=0 are ignored.
//  DECODE: 1 cycle; classify ir[6:0]. Unknown opcode -> TRAP with fault_code 01.
//  Decode-derived selects (alu_src, imm_sel, wb_sel, pc_sel) are combinational from ir.
//    They are valid in EXEC, MEM and WB; 0 elsewhere.
//    alu_src=1 for 0x13/0x03/0x23/0x37, else 0.
//  EXEC: 1 cycle.
//    0x63: pc_we=1, pc_sel=01 if branch_taken else 00; retire; -> FETCH.
//    0x6F: reg_we=1, wb_sel=10, pc_we=1, pc_sel=10; retire; -> FETCH.
//    0x03/0x23: -> MEM.
//    0x13/0x33/0x37: -> WB.
//  MEM: dmem_req=1, dmem_we=1 only for 0x23; held until dmem_ack.
//    Store: on ack, pc_we=1 with pc_sel=00, retire, -> FETCH (same cycle as ack).
//    Load: on ack -> WB.
//  WB: reg_we=1, pc_we=1, pc_sel=00, retire; -> FETCH.
//    wb_sel: 01 for load, 11 for lui, 00 otherwise.
//  reg_we and pc_we each assert at most one cycle per instruction.
//  rd=x0 is not special-cased; the register file discards x0 writes.
//  Latency (zero-wait ack): branch/jal 3 cycles, ALU/lui 4, store 4, load 5.
//  Timeout: counter increments each cycle a req is high without its ack.
//    It clears on ack or on a state change.
//    When it equals MEM_TIMEOUT (if nonzero) -> TRAP, code 10 (imem) or 11 (dmem).
//    An ack arriving on the same cycle as the limit wins; no trap.
//  TRAP: all strobes 0, fault=1, fault_code held; exit only via rst.
//  retire_cnt increments on each retire pulse; wraps from all-ones to 0.
// TESTING
//  addi x1,x0,5 (0x00500093), acks zero-wait
//    -> WB in cycle 4: reg_we=1, wb_sel=00, alu_src=1, imm_sel=000; retire_cnt=1.
//  lw x2,0(x1) (0x0000A103), dmem_ack 2 cycles late
//    -> dmem_req high 3 cycles with dmem_we=0; then WB with wb_sel=01.
//  bne (0x00209463): branch_taken=1 -> EXEC pc_we=1, pc_sel=01; with 0 -> pc_sel=00.
//    reg_we never asserts.
//  jal x1,8 (0x008000EF) -> EXEC: reg_we=1, wb_sel=10, pc_sel=10, imm_sel=100.
//  sw (0x0020A023) -> dmem_we=1; pc_we=1 with pc_sel=00 on the ack cycle; no reg_we.
//  instr 0x00000000 -> TRAP, fault_code=01, imem_req stays 0.
//    imem_ack low 15 cycles -> fault_code=10.
//    rst during MEM -> next cycle: FETCH, dmem_req=0, retire_cnt=0.

Source files
------------

// File: rtl/riscv_seq_ctrl.sv
// ============================================================================
// riscv_seq_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle sequencer for a small RV32I core. Walks every instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and produces the memory
// handshakes, PC load strobe, register write strobe and datapath selects
// for the opcode subset 0x13, 0x03, 0x33, 0x6F, 0x23, 0x37 and 0x63.
// Illegal opcodes and memory requests that wait too long for their ack
// drop the sequencer into a sticky TRAP state that only rst leaves.
//
// Parameters
//   MEM_TIMEOUT   cycles a request may wait for its ack before trapping
//                 (0 disables the timeout)
//   CNT_W         width of retire_cnt
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   imem_req      instruction fetch request (high in FETCH)
//   imem_ack      fetch complete, instr valid this cycle
//   instr         fetched instruction word
//   dmem_req      data memory request (high in MEM)
//   dmem_we       1 = store, 0 = load; qualified by dmem_req
//   dmem_ack      data access complete
//   branch_taken  ALU compare result used by bne
//   ir            latched instruction register
//   pc_we         PC load strobe
//   pc_sel        00 pc+4, 01 branch target, 10 jal target
//   reg_we        register file write strobe
//   wb_sel        00 ALU, 01 load data, 10 pc+4, 11 U-immediate
//   alu_src       0 = rs2, 1 = immediate
//   imm_sel       000 I, 001 S, 010 B, 011 U, 100 J
//   retire        one-cycle pulse per completed instruction
//   retire_cnt    retired instruction count, wraps to 0
//   fault         sticky trap flag
//   fault_code    01 illegal opcode, 10 imem timeout, 11 dmem timeout
//   state         current FSM state, for debug visibility
// ============================================================================
module riscv_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    output logic [31:0]      ir,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [2:0]       imm_sel,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_ALUI   = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_ALU    = 7'h33;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_IMEM_TO = 2'b10;
    localparam logic [1:0] FC_DMEM_TO = 2'b11;

    // Wide enough to hold MEM_TIMEOUT itself; at least one bit so the
    // counter still exists when the timeout is disabled.
    localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [31:0]       ir_q,         ir_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              fault_q,      fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [TO_W-1:0]   to_cnt_q,     to_cnt_d;

    // ------------------------------------------------------------------
    // Opcode classification of the latched instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic       is_alui;
    logic       is_load;
    logic       is_alu;
    logic       is_jal;
    logic       is_store;
    logic       is_lui;
    logic       is_branch;
    logic       is_legal;

    always_comb begin
        opcode    = ir_q[6:0];
        is_alui   = (opcode == OP_ALUI);
        is_load   = (opcode == OP_LOAD);
        is_alu    = (opcode == OP_ALU);
        is_jal    = (opcode == OP_JAL);
        is_store  = (opcode == OP_STORE);
        is_lui    = (opcode == OP_LUI);
        is_branch = (opcode == OP_BRANCH);
        is_legal  = is_alui | is_load | is_alu | is_jal
                  | is_store | is_lui | is_branch;
    end

    // ------------------------------------------------------------------
    // Handshake timeout
    // The counter holds the number of cycles already spent waiting. The
    // trap fires on the cycle whose increment would reach the limit, but
    // only when no ack is present, so an ack on that cycle wins.
    // ------------------------------------------------------------------
    logic [TO_W-1:0] to_inc;
    logic            imem_wait;
    logic            dmem_wait;
    logic            to_hit;

    always_comb begin
        to_inc    = to_cnt_q + 1'b1;
        imem_wait = (state_q == ST_FETCH) && !imem_ack;
        dmem_wait = (state_q == ST_MEM)   && !dmem_ack;
        to_hit    = TO_EN && (imem_wait || dmem_wait) && (to_inc == TO_LIMIT);
    end

    // ------------------------------------------------------------------
    // Strobes and selects
    // Strobes depend on the current state (and on dmem_ack for the store
    // completion), so they line up with the cycle the action happens in.
    // rst forces everything quiet while it is asserted.
    // ------------------------------------------------------------------
    logic sel_valid;

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_sel    = 2'b00;
        wb_sel    = 2'b00;
        alu_src   = 1'b0;
        imm_sel   = 3'b000;
        sel_valid = !rst && ((state_q == ST_EXEC) || (state_q == ST_MEM)
                             || (state_q == ST_WB));

        if (sel_valid) begin
            alu_src = is_alui | is_load | is_store | is_lui;

            if (is_store)       imm_sel = 3'b001;
            else if (is_branch) imm_sel = 3'b010;
            else if (is_lui)    imm_sel = 3'b011;
            else if (is_jal)    imm_sel = 3'b100;
            else                imm_sel = 3'b000;

            if (is_jal)       wb_sel = 2'b10;
            else if (is_load) wb_sel = 2'b01;
            else if (is_lui)  wb_sel = 2'b11;
            else              wb_sel = 2'b00;

            if (is_jal)                         pc_sel = 2'b10;
            else if (is_branch && branch_taken) pc_sel = 2'b01;
            else                                pc_sel = 2'b00;
        end

        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                end
                ST_EXEC: begin
                    pc_we  = is_branch | is_jal;
                    reg_we = is_jal;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    // Stores complete in MEM; loads still need WB.
                    pc_we    = is_store && dmem_ack;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                end
                default: begin
                end
            endcase
        end

        // Every instruction updates the PC exactly once, on its final cycle.
        retire = pc_we;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        to_cnt_d     = '0;
        retire_cnt_d = retire ? (retire_cnt_q + 1'b1) : retire_cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end else if (to_hit) begin
                    state_d      = ST_TRAP;
                    fault_d      = 1'b1;
                    fault_code_d = FC_IMEM_TO;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d      = ST_TRAP;
                    fault_d      = 1'b1;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_branch || is_jal)      state_d = ST_FETCH;
                else if (is_load || is_store) state_d = ST_MEM;
                else                          state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = is_store ? ST_FETCH : ST_WB;
                end else if (to_hit) begin
                    state_d      = ST_TRAP;
                    fault_d      = 1'b1;
                    fault_code_d = FC_DMEM_TO;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            ir_q         <= '0;
            retire_cnt_q <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            retire_cnt_q <= retire_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign ir         = ir_q;
    assign retire_cnt = retire_cnt_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// ============================================================================
// tb_riscv_seq_ctrl
// Directed testbench for riscv_seq_ctrl: drives instruction words and
// handshake timing by hand and compares strobes/selects against values
// worked out from the instruction sequence.
// ============================================================================
module tb_riscv_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] ir;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        alu_src;
    logic [2:0]  imm_sel;
    logic        retire;
    logic [31:0] retire_cnt;
    logic        fault;
    logic [1:0]  fault_code;
    logic [2:0]  state;

    int total;
    int bad;
    int exp_cnt;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LUI  = 32'h000010B7;
    localparam logic [31:0] I_ADD  = 32'h002081B3;

    riscv_seq_ctrl #(
        .MEM_TIMEOUT(15),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .branch_taken(branch_taken),
        .ir          (ir),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .alu_src     (alu_src),
        .imm_sel     (imm_sel),
        .retire      (retire),
        .retire_cnt  (retire_cnt),
        .fault       (fault),
        .fault_code  (fault_code),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Called in FETCH: ack the fetch this cycle, end up in DECODE.
    task automatic fetch(input logic [31:0] w);
        imem_ack = 1'b1;
        instr    = w;
        #1;
        check_val("fetch_imem_req", imem_req, 1);
        step();
        imem_ack = 1'b0;
        instr    = 32'h0;
        #1;
        check_val("decode_state", state, 1);
        check_val("decode_ir", ir, w);
        check_val("decode_reg_we", reg_we, 0);
    endtask

    // ALU / lui style: FETCH, DECODE, EXEC, WB.
    task automatic run_wb(input string name, input logic [31:0] w,
                          input logic [1:0] exp_wb, input logic exp_src,
                          input logic [2:0] exp_imm);
        fetch(w);
        step();
        check_val({name, "_exec_state"}, state, 2);
        check_val({name, "_exec_pc_we"}, pc_we, 0);
        step();
        check_val({name, "_wb_state"}, state, 4);
        check_val({name, "_wb_reg_we"}, reg_we, 1);
        check_val({name, "_wb_pc_we"}, pc_we, 1);
        check_val({name, "_wb_pc_sel"}, pc_sel, 0);
        check_val({name, "_wb_sel"}, wb_sel, exp_wb);
        check_val({name, "_alu_src"}, alu_src, exp_src);
        check_val({name, "_imm_sel"}, imm_sel, exp_imm);
        check_val({name, "_retire"}, retire, 1);
        step();
        exp_cnt++;
        check_val({name, "_done_state"}, state, 0);
        check_val({name, "_retire_cnt"}, retire_cnt, exp_cnt);
        check_val({name, "_done_reg_we"}, reg_we, 0);
        $display("txn %s instr=0x%08h retire_cnt=%0d", name, w, retire_cnt);
    endtask

    task automatic run_bne(input logic taken, input logic [1:0] exp_sel);
        fetch(I_BNE);
        branch_taken = taken;
        step();
        check_val("bne_exec_state", state, 2);
        check_val("bne_pc_we", pc_we, 1);
        check_val("bne_pc_sel", pc_sel, exp_sel);
        check_val("bne_reg_we", reg_we, 0);
        check_val("bne_imm_sel", imm_sel, 2);
        check_val("bne_retire", retire, 1);
        step();
        branch_taken = 1'b0;
        exp_cnt++;
        check_val("bne_done_state", state, 0);
        check_val("bne_retire_cnt", retire_cnt, exp_cnt);
        $display("txn bne taken=%0d pc_sel=%0d retire_cnt=%0d", taken, exp_sel, retire_cnt);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        exp_cnt      = 0;
        rst          = 1'b1;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        instr        = 32'h0;
        branch_taken = 1'b0;

        // Reset values
        step();
        step();
        check_val("rst_state", state, 0);
        check_val("rst_ir", ir, 0);
        check_val("rst_retire_cnt", retire_cnt, 0);
        check_val("rst_fault", fault, 0);
        check_val("rst_fault_code", fault_code, 0);
        check_val("rst_imem_req", imem_req, 0);
        check_val("rst_pc_we", pc_we, 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_imem_req", imem_req, 1);
        $display("txn reset");

        // addi x1,x0,5
        run_wb("addi", I_ADDI, 2'b00, 1'b1, 3'b000);

        // lw x2,0(x1) with dmem_ack two cycles late
        fetch(I_LW);
        step();
        check_val("lw_exec_state", state, 2);
        step();
        check_val("lw_mem_state", state, 3);
        check_val("lw_dmem_req1", dmem_req, 1);
        check_val("lw_dmem_we", dmem_we, 0);
        step();
        check_val("lw_dmem_req2", dmem_req, 1);
        step();
        dmem_ack = 1'b1;
        #1;
        check_val("lw_dmem_req3", dmem_req, 1);
        check_val("lw_ack_pc_we", pc_we, 0);
        step();
        dmem_ack = 1'b0;
        #1;
        check_val("lw_wb_state", state, 4);
        check_val("lw_wb_sel", wb_sel, 1);
        check_val("lw_wb_reg_we", reg_we, 1);
        check_val("lw_wb_dmem_req", dmem_req, 0);
        step();
        exp_cnt++;
        check_val("lw_retire_cnt", retire_cnt, exp_cnt);
        $display("txn lw retire_cnt=%0d", retire_cnt);

        // bne taken and not taken
        run_bne(1'b1, 2'b01);
        run_bne(1'b0, 2'b00);

        // jal x1,8
        fetch(I_JAL);
        step();
        check_val("jal_reg_we", reg_we, 1);
        check_val("jal_wb_sel", wb_sel, 2);
        check_val("jal_pc_we", pc_we, 1);
        check_val("jal_pc_sel", pc_sel, 2);
        check_val("jal_imm_sel", imm_sel, 4);
        step();
        exp_cnt++;
        check_val("jal_done_state", state, 0);
        check_val("jal_retire_cnt", retire_cnt, exp_cnt);
        $display("txn jal retire_cnt=%0d", retire_cnt);

        // sw: completes on the ack cycle
        fetch(I_SW);
        step();
        check_val("sw_imm_sel", imm_sel, 1);
        step();
        check_val("sw_mem_state", state, 3);
        check_val("sw_dmem_we", dmem_we, 1);
        check_val("sw_wait_pc_we", pc_we, 0);
        dmem_ack = 1'b1;
        #1;
        check_val("sw_ack_pc_we", pc_we, 1);
        check_val("sw_ack_pc_sel", pc_sel, 0);
        check_val("sw_ack_reg_we", reg_we, 0);
        check_val("sw_ack_retire", retire, 1);
        step();
        dmem_ack = 1'b0;
        #1;
        exp_cnt++;
        check_val("sw_done_state", state, 0);
        check_val("sw_retire_cnt", retire_cnt, exp_cnt);
        $display("txn sw retire_cnt=%0d", retire_cnt);

        // lui and register-register add
        run_wb("lui", I_LUI, 2'b11, 1'b1, 3'b011);
        run_wb("add", I_ADD, 2'b00, 1'b0, 3'b000);

        // imem ack arriving on the limit cycle wins over the timeout
        repeat (14) step();
        check_val("late_ack_state", state, 0);
        run_wb("addi_late", I_ADDI, 2'b00, 1'b1, 3'b000);

        // Illegal opcode
        fetch(32'h00000000);
        step();
        check_val("ill_state", state, 5);
        check_val("ill_fault", fault, 1);
        check_val("ill_fault_code", fault_code, 1);
        check_val("ill_imem_req", imem_req, 0);
        imem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        check_val("ill_stay_state", state, 5);
        check_val("ill_stay_imem_req", imem_req, 0);
        check_val("ill_stay_retire_cnt", retire_cnt, exp_cnt);
        $display("txn illegal fault_code=%0d", fault_code);

        // imem timeout
        do_reset();
        exp_cnt = 0;
        check_val("to_rst_fault", fault, 0);
        check_val("to_rst_retire_cnt", retire_cnt, 0);
        repeat (14) step();
        check_val("imem_to_wait_state", state, 0);
        step();
        check_val("imem_to_state", state, 5);
        check_val("imem_to_fault", fault, 1);
        check_val("imem_to_code", fault_code, 2);
        check_val("imem_to_req", imem_req, 0);
        $display("txn imem_timeout fault_code=%0d", fault_code);

        // dmem timeout
        do_reset();
        fetch(I_LW);
        step();
        step();
        repeat (14) step();
        check_val("dmem_to_wait_state", state, 3);
        check_val("dmem_to_wait_req", dmem_req, 1);
        step();
        check_val("dmem_to_state", state, 5);
        check_val("dmem_to_code", fault_code, 3);
        check_val("dmem_to_req", dmem_req, 0);
        $display("txn dmem_timeout fault_code=%0d", fault_code);

        // Reset during MEM
        do_reset();
        exp_cnt = 0;
        run_wb("addi_pre", I_ADDI, 2'b00, 1'b1, 3'b000);
        fetch(I_LW);
        step();
        step();
        check_val("rstmem_state", state, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("rstmem_after_state", state, 0);
        check_val("rstmem_dmem_req", dmem_req, 0);
        check_val("rstmem_retire_cnt", retire_cnt, 0);
        check_val("rstmem_imem_req", imem_req, 1);
        $display("txn reset_in_mem state=%0d", state);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
